// File: rtl/br_stack.sv
`default_nettype none
// ============================================================================
//  Module      : br_stack
//  Description : Branch-target unit with a register-based return-address
//                stack. Decodes the branch-class op in execute, evaluates the
//                condition mask against the status flags and drives the
//                next-PC target and select into the PC stage with zero added
//                latency. BSR pushes PC+1, RTS pops it; overflow/underflow
//                fall through to PC+1 and set a sticky error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module br_stack #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             br_rst,
    input  logic             br_en,
    input  logic [2:0]       br_op,
    input  logic [15:0]      br_imm,
    input  logic [3:0]       br_mask,
    input  logic [3:0]       stat,
    input  logic [15:0]      pc_inc,
    output logic [15:0]      br_addr,
    output logic             pc_sel,
    output logic [CNT_W-1:0] stk_cnt,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             br_err
);

    // Index width into the entry array; DEPTH == 2**c_IDX_W.
    localparam int c_IDX_W = CNT_W - 1;

    localparam logic [2:0] c_OP_BRR = 3'b001;
    localparam logic [2:0] c_OP_BRA = 3'b010;
    localparam logic [2:0] c_OP_BSR = 3'b011;
    localparam logic [2:0] c_OP_RTS = 3'b100;

    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0]   stk_cnt_q, stk_cnt_d;
    logic               br_err_q,  br_err_d;
    logic [15:0]        stack_q [DEPTH];
    logic [15:0]        stack_d [DEPTH];

    logic               w_cond;
    logic               w_full;
    logic               w_empty;
    logic [c_IDX_W-1:0] w_push_idx;
    logic [c_IDX_W-1:0] w_top_idx;

    // Status decode from the registered count only, so full/empty never glitch.
    always_comb begin
        w_cond     = (br_mask & stat) != 4'b0000;
        w_full     = (stk_cnt_q == c_CNT_FULL);
        w_empty    = (stk_cnt_q == '0);
        // The low bits of the count address the next free slot; when the
        // stack is full they wrap to 0, which still yields the correct top.
        w_push_idx = stk_cnt_q[c_IDX_W-1:0];
        w_top_idx  = stk_cnt_q[c_IDX_W-1:0] - c_IDX_W'(1);
    end

    // Next-PC target and select; overflowed calls and empty returns fall through to PC+1.
    always_comb begin
        br_addr = pc_inc;
        pc_sel  = 1'b0;
        case (br_op)
            c_OP_BRR: begin
                br_addr = pc_inc + br_imm;
                pc_sel  = br_en & w_cond;
            end
            c_OP_BRA: begin
                br_addr = br_imm;
                pc_sel  = br_en & w_cond;
            end
            c_OP_BSR: begin
                if (!w_full) begin
                    br_addr = br_imm;
                    pc_sel  = br_en;
                end
            end
            c_OP_RTS: begin
                if (!w_empty) begin
                    br_addr = stack_q[w_top_idx];
                    pc_sel  = br_en;
                end
            end
            default: begin
                br_addr = pc_inc;
                pc_sel  = 1'b0;
            end
        endcase
    end

    // Stack push/pop and sticky error next-state; at most one push or pop per cycle.
    always_comb begin
        stk_cnt_d = stk_cnt_q;
        br_err_d  = br_err_q;
        stack_d   = stack_q;
        if (br_en) begin
            case (br_op)
                c_OP_BSR: begin
                    if (w_full) begin
                        br_err_d = 1'b1;
                    end else begin
                        stack_d[w_push_idx] = pc_inc;
                        stk_cnt_d           = stk_cnt_q + CNT_W'(1);
                    end
                end
                c_OP_RTS: begin
                    if (w_empty) begin
                        br_err_d = 1'b1;
                    end else begin
                        stk_cnt_d = stk_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    stk_cnt_d = stk_cnt_q;
                end
            endcase
        end
    end

    // State registers; reset overrides any strobe at the same edge.
    always_ff @(posedge clk) begin
        if (br_rst) begin
            stk_cnt_q <= '0;
            br_err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= 16'h0000;
            end
        end else begin
            stk_cnt_q <= stk_cnt_d;
            br_err_q  <= br_err_d;
            stack_q   <= stack_d;
        end
    end

    // Registered status outputs.
    always_comb begin
        stk_cnt   = stk_cnt_q;
        stk_full  = w_full;
        stk_empty = w_empty;
        br_err    = br_err_q;
    end

endmodule
`default_nettype wire
